// File: rtl/aes256_inv_key_schedule_if.sv
`default_nettype none
// ============================================================================
// Module      : aes256_inv_key_schedule_if
// Description : Load / round-key / cipher-key bundle for the AES-256 inverse
//               key schedule. The slave modport is the schedule itself; the
//               master modport is the key store / round datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes256_inv_key_schedule_if #(
  parameter int KEY_WIDTH = 256
);
  logic [KEY_WIDTH-1:0]   last_key_i;
  logic                   last_key_valid_i;
  logic                   last_key_ready_o;
  logic [KEY_WIDTH/2-1:0] round_key_o;
  logic [3:0]             round_key_idx_o;
  logic                   round_key_valid_o;
  logic                   round_key_ready_i;
  logic [KEY_WIDTH-1:0]   cipher_key_o;
  logic                   cipher_key_valid_o;

  modport master (
    output last_key_i, last_key_valid_i, round_key_ready_i,
    input  last_key_ready_o, round_key_o, round_key_idx_o, round_key_valid_o,
    input  cipher_key_o, cipher_key_valid_o
  );

  modport slave (
    input  last_key_i, last_key_valid_i, round_key_ready_i,
    output last_key_ready_o, round_key_o, round_key_idx_o, round_key_valid_o,
    output cipher_key_o, cipher_key_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/aes256_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes256_inv_key_schedule
// Description : Runs the AES-256 key schedule backwards. Takes w52..w59,
//               regenerates one earlier word per cycle in an 8-word window,
//               streams round keys 14..0 and returns the cipher key w0..w7.
//               Optional macro AES_EQ_INV_CIPHER_EN: round keys 13..1 leave
//               through InvMixColumns for the equivalent inverse cipher.
// Revision    : 1.0 - initial release
// ============================================================================
module aes256_inv_key_schedule #(
  parameter int KEY_WIDTH  = 256,
  parameter int NUM_ROUNDS = 14
) (
  input  logic                      clk,
  input  logic                      reset,
  aes256_inv_key_schedule_if.slave  bus
);

  generate
    if (KEY_WIDTH != 256 || NUM_ROUNDS != 14) begin : g_bad_config
      $error("aes256_inv_key_schedule: only KEY_WIDTH=256 / NUM_ROUNDS=14 supported");
    end
  endgenerate

  localparam logic [3:0] c_LAST_IDX = 4'(NUM_ROUNDS);
  localparam logic [5:0] c_BASE0    = 6'(4 * NUM_ROUNDS - 4);

  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return c_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

`ifdef AES_EQ_INV_CIPHER_EN
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_win [8];
  logic [3:0]    r_idx;
  logic [5:0]    r_base;
  logic [1:0]    r_step_cnt;
  logic [255:0]  r_cipher_key;

  logic [5:0]    w_j;
  logic [31:0]   w_rot;
  logic [31:0]   w_sub;
  logic [7:0]    w_rcon;
  logic [31:0]   w_g;
  logic [31:0]   w_new_word;
  logic [127:0]  w_rk_raw;
  logic [127:0]  w_rk;

  // Backward word: w[j] = w[j+8] ^ g(w[j+7]), j = base-1, g chosen by j mod 8
  assign w_j = r_base - 6'd1;

  always_comb begin
    w_rot  = {r_win[6][23:0], r_win[6][31:24]};
    w_sub  = sub_word((w_j[2:0] == 3'd0) ? w_rot : r_win[6]);
    w_rcon = 8'h01 << w_j[5:3];
    case (w_j[2:0])
      3'd0:    w_g = w_sub ^ {w_rcon, 24'h000000};
      3'd4:    w_g = w_sub;
      default: w_g = r_win[6];
    endcase
    w_new_word = r_win[7] ^ w_g;
  end

  // State register; reset aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: round 14 comes straight from the loaded top half, 13 from the
  // bottom half, every later round needs four backward steps first
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.last_key_valid_i) w_state_nxt = S_EMIT;
      S_EMIT: begin
        if (bus.round_key_ready_i) begin
          if (r_idx == 4'd0)            w_state_nxt = S_DONE;
          else if (r_idx == c_LAST_IDX) w_state_nxt = S_EMIT;
          else                          w_state_nxt = S_STEP;
        end
      end
      S_STEP: if (r_step_cnt == 2'd3) w_state_nxt = S_EMIT;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Window, round index, step counter and recovered-key register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) r_win[i] <= '0;
      r_idx        <= '0;
      r_base       <= '0;
      r_step_cnt   <= '0;
      r_cipher_key <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.last_key_valid_i) begin
            for (int i = 0; i < 8; i++) r_win[i] <= bus.last_key_i[255-32*i -: 32];
            r_idx      <= c_LAST_IDX;
            r_base     <= c_BASE0;
            r_step_cnt <= '0;
          end
        end
        S_EMIT: begin
          if (bus.round_key_ready_i) begin
            if (r_idx == 4'd0)
              r_cipher_key <= {r_win[0], r_win[1], r_win[2], r_win[3],
                               r_win[4], r_win[5], r_win[6], r_win[7]};
            else
              r_idx <= r_idx - 4'd1;
          end
        end
        S_STEP: begin
          r_win[0] <= w_new_word;
          for (int i = 1; i < 8; i++) r_win[i] <= r_win[i-1];
          r_base     <= r_base - 6'd1;
          r_step_cnt <= r_step_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Round-key select; the equivalent-cipher transform sits purely on the output
  always_comb begin
    w_rk_raw = (r_idx == c_LAST_IDX) ? {r_win[4], r_win[5], r_win[6], r_win[7]}
                                     : {r_win[0], r_win[1], r_win[2], r_win[3]};
`ifdef AES_EQ_INV_CIPHER_EN
    if (r_idx != c_LAST_IDX && r_idx != 4'd0)
      w_rk = {inv_mix_col(w_rk_raw[127:96]), inv_mix_col(w_rk_raw[95:64]),
              inv_mix_col(w_rk_raw[63:32]),  inv_mix_col(w_rk_raw[31:0])};
    else
      w_rk = w_rk_raw;
`else
    w_rk = w_rk_raw;
`endif
  end

  assign bus.last_key_ready_o   = (r_state == S_IDLE) && !reset;
  assign bus.round_key_o        = w_rk;
  assign bus.round_key_idx_o    = r_idx;
  assign bus.round_key_valid_o  = (r_state == S_EMIT);
  assign bus.cipher_key_o       = r_cipher_key;
  assign bus.cipher_key_valid_o = (r_state == S_DONE);

endmodule
`default_nettype wire
